// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types and constants for the Wishbone bus cycle sequencer
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  localparam logic        TGA_MEM  = 1'b0;
  localparam logic        TGA_IO   = 1'b1;
  localparam int          WAIT_W   = 4;
  localparam logic [15:0] ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - strobe wait-state down-counter with optional IORDY stretch timeout
// Optional feature macro: BUSCTRL_TIMEOUT_EN
module bus_wait_timer
  import bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              active,
  input  logic              ready,
  output logic              done,
  output logic              timeout
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic [WAIT_W-1:0] count;
  logic              zero;

  assign zero = (count == '0);
  assign done = active && zero && ready;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (active && !zero)
      count <= count - 1'b1;
  end

`ifdef BUSCTRL_TIMEOUT_EN
  logic [15:0] stretch;

  // Only cycles where the programmed waits are spent and IORDY holds us count.
  always_ff @(posedge clk) begin
    if (rst || load)
      stretch <= '0;
    else if (active && zero && !ready && stretch != TMO)
      stretch <= stretch + 16'd1;
  end

  assign timeout = active && zero && !ready && (stretch == TMO);
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign timeout    = 1'b0;
`endif

endmodule

// File: rtl/wb_bus_cycle_ctrl.sv
// rtl/wb_bus_cycle_ctrl.sv - Wishbone request to timed device cycle (CS decode, RDN/WRN, waits, IORDY)
// Optional feature macro: BUSCTRL_TIMEOUT_EN
module wb_bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 1,
  parameter int IO_WAIT    = 3,
  parameter int IO_DEC_BIT = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic        wb_tga_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [15:0] ADDR,
  output logic [15:0] DATW,
  output logic        RDN,
  output logic        WRN,
  output logic        MEMCS_N,
  output logic        IOCS0_N,
  output logic        IOCS1_N,
  input  logic [15:0] MEMDATI,
  input  logic [15:0] IODAT0I,
  input  logic [15:0] IODAT1I,
  input  logic        IORDY
);

  state_t            state;
  logic              we_q;
  logic              tga_q;
  logic              port_q;
  logic              aborted;
  logic              tmr_done;
  logic              tmr_timeout;
  logic              tmr_ready;
  logic [WAIT_W-1:0] wait_val;
  logic [15:0]       rd_data;

  assign tmr_ready = (tga_q == TGA_MEM) || IORDY;
  assign wait_val  = (tga_q == TGA_IO) ? WAIT_W'(IO_WAIT) : WAIT_W'(MEM_WAIT);
  assign rd_data   = (tga_q == TGA_MEM) ? MEMDATI : (port_q ? IODAT1I : IODAT0I);

  bus_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (state == ST_SETUP),
    .load_val(wait_val),
    .active  (state == ST_STROBE),
    .ready   (tmr_ready),
    .done    (tmr_done),
    .timeout (tmr_timeout)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      we_q     <= 1'b0;
      tga_q    <= TGA_MEM;
      port_q   <= 1'b0;
      aborted  <= 1'b0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      ADDR     <= '0;
      DATW     <= '0;
      RDN      <= 1'b1;
      WRN      <= 1'b1;
      MEMCS_N  <= 1'b1;
      IOCS0_N  <= 1'b1;
      IOCS1_N  <= 1'b1;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            ADDR   <= wb_adr_i;
            DATW   <= wb_dat_i;
            we_q   <= wb_we_i;
            tga_q  <= wb_tga_i;
            port_q <= wb_adr_i[IO_DEC_BIT];
            // Chip select goes out with the request so it is valid for the whole SETUP cycle.
            if (wb_tga_i == TGA_MEM)
              MEMCS_N <= 1'b0;
            else if (wb_adr_i[IO_DEC_BIT])
              IOCS1_N <= 1'b0;
            else
              IOCS0_N <= 1'b0;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          RDN   <= we_q;
          WRN   <= !we_q;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (tmr_timeout) begin
            RDN      <= 1'b1;
            WRN      <= 1'b1;
            aborted  <= 1'b1;
            wb_dat_o <= ERR_DATA;
            state    <= ST_HOLD;
          end else if (tmr_done) begin
            RDN <= 1'b1;
            WRN <= 1'b1;
            if (!we_q)
              wb_dat_o <= rd_data;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          MEMCS_N  <= 1'b1;
          IOCS0_N  <= 1'b1;
          IOCS1_N  <= 1'b1;
          // A master that gave up mid-transfer gets no response at all.
          wb_ack_o <= wb_cyc_i && !aborted;
          wb_err_o <= wb_cyc_i && aborted;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          aborted <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_cycle_ctrl.sv
// tb/tb_wb_bus_cycle_ctrl.sv - self-checking bench for wb_bus_cycle_ctrl (honours BUSCTRL_TIMEOUT_EN)
module tb_wb_bus_cycle_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic        wb_tga_i = 1'b0;
  logic [15:0] wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [15:0] ADDR;
  logic [15:0] DATW;
  logic        RDN;
  logic        WRN;
  logic        MEMCS_N;
  logic        IOCS0_N;
  logic        IOCS1_N;
  logic [15:0] MEMDATI = '0;
  logic [15:0] IODAT0I = '0;
  logic [15:0] IODAT1I = '0;
  logic        IORDY   = 1'b1;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_bus_cycle_ctrl #(
    .MEM_WAIT  (1),
    .IO_WAIT   (3),
    .IO_DEC_BIT(8),
    .TIMEOUT   (16)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),  .wb_tga_i(wb_tga_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ADDR(ADDR), .DATW(DATW), .RDN(RDN), .WRN(WRN),
    .MEMCS_N(MEMCS_N), .IOCS0_N(IOCS0_N), .IOCS1_N(IOCS1_N),
    .MEMDATI(MEMDATI), .IODAT0I(IODAT0I), .IODAT1I(IODAT1I), .IORDY(IORDY)
  );

  typedef struct {
    logic        err;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mdl_dat = '0;
  int          lo_from = 0;
  int          lo_to   = 0;
  int          drop_at = 0;

  logic h_rdn [0:63];
  logic h_wrn [0:63];
  logic h_mcs [0:63];
  logic h_cs0 [0:63];
  logic h_cs1 [0:63];
  logic h_err [0:63];

  // Issues one request at edge 0 and records cycles 1..ncyc; responses are scored against sb.
  task automatic run_txn(input logic we, input logic tga, input logic [15:0] adr,
                         input logic [15:0] dat, input int ncyc);
    exp_t e;
    int   ncs;
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_tga_i = tga;
    wb_adr_i = adr;  wb_dat_i = dat;  IORDY = 1'b1;
    @(posedge wb_clk_i);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge wb_clk_i);
      wb_stb_i = 1'b0;
      if (drop_at != 0 && k >= drop_at) wb_cyc_i = 1'b0;
      IORDY = !(k >= lo_from && k <= lo_to);
      h_rdn[k] = RDN; h_wrn[k] = WRN; h_mcs[k] = MEMCS_N;
      h_cs0[k] = IOCS0_N; h_cs1[k] = IOCS1_N; h_err[k] = wb_err_o;
      n_cmp++;
      if (!RDN && !WRN) begin
        n_bad++; $display("FAIL strobe_excl cyc%0d: RDN=%b WRN=%b want not both 0", k, RDN, WRN);
      end
      ncs = int'(!MEMCS_N) + int'(!IOCS0_N) + int'(!IOCS1_N);
      n_cmp++;
      if (ncs > 1) begin
        n_bad++; $display("FAIL cs_excl cyc%0d: %0d selects low, want <=1", k, ncs);
      end
      if (wb_ack_o || wb_err_o) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL unexpected_resp cyc%0d: ack=%b err=%b want none", k, wb_ack_o, wb_err_o);
        end else begin
          e = sb.pop_front();
          if ({wb_err_o, wb_ack_o} !== {e.err, !e.err}) begin
            n_bad++; $display("FAIL resp_kind cyc%0d: err/ack=%b%b want %b%b", k, wb_err_o, wb_ack_o, e.err, !e.err);
          end
          n_cmp++;
          if (wb_dat_o !== e.dat) begin
            n_bad++; $display("FAIL rdata cyc%0d: got %h want %h", k, wb_dat_o, e.dat);
          end
          if (e.cyc > 0) begin
            n_cmp++;
            if (k !== e.cyc) begin
              n_bad++; $display("FAIL resp_cycle: got %0d want %0d", k, e.cyc);
            end
          end
        end
        wb_cyc_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0; IORDY = 1'b1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL missing_resp: %0d outstanding want 0", sb.size());
      sb.delete();
    end
    lo_from = 0; lo_to = 0; drop_at = 0;
  endtask

  task automatic push_exp(input logic err, input logic [15:0] dat, input int cyc);
    exp_t e;
    e.err = err; e.dat = dat; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_cmp++;
    if ({RDN, WRN, MEMCS_N, IOCS0_N, IOCS1_N} !== 5'b11111) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 11111", {RDN, WRN, MEMCS_N, IOCS0_N, IOCS1_N});
    end
    n_cmp++;
    if ({wb_ack_o, wb_err_o} !== 2'b00) begin
      n_bad++; $display("FAIL reset_resp: got %b want 00", {wb_ack_o, wb_err_o});
    end
    n_cmp++;
    if ({wb_dat_o, ADDR, DATW} !== 48'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {wb_dat_o, ADDR, DATW});
    end
    wb_rst_i = 1'b0;
    mdl_dat  = '0;
  endtask

  task automatic test_mem_read();
    MEMDATI = 16'hA55A;
    mdl_dat = 16'hA55A;
    push_exp(1'b0, mdl_dat, 5);
    run_txn(1'b0, 1'b0, 16'h1234, 16'h0, 8);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if ({h_mcs[k], h_rdn[k], h_wrn[k], h_cs0[k], h_cs1[k]} !==
          {!(k >= 1 && k <= 4), !(k >= 2 && k <= 3), 3'b111}) begin
        n_bad++; $display("FAIL mem_rd_pins cyc%0d: mcs/rdn/wrn/cs0/cs1=%b%b%b%b%b", k,
                          h_mcs[k], h_rdn[k], h_wrn[k], h_cs0[k], h_cs1[k]);
      end
    end
    n_cmp++;
    if (ADDR !== 16'h1234) begin
      n_bad++; $display("FAIL mem_rd_addr: got %h want 1234", ADDR);
    end
  endtask

  task automatic test_io_write();
    push_exp(1'b0, mdl_dat, 7);
    run_txn(1'b1, 1'b1, 16'h0100, 16'hBEEF, 10);
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if ({h_cs1[k], h_wrn[k], h_rdn[k], h_cs0[k], h_mcs[k]} !==
          {!(k >= 1 && k <= 6), !(k >= 2 && k <= 5), 3'b111}) begin
        n_bad++; $display("FAIL io_wr_pins cyc%0d: cs1/wrn/rdn/cs0/mcs=%b%b%b%b%b", k,
                          h_cs1[k], h_wrn[k], h_rdn[k], h_cs0[k], h_mcs[k]);
      end
    end
    n_cmp++;
    if (DATW !== 16'hBEEF) begin
      n_bad++; $display("FAIL io_wr_datw: got %h want beef", DATW);
    end
  endtask

  task automatic test_io_read_stretch();
    IODAT0I = 16'h5A5A;
    IODAT1I = 16'h0F00;
    mdl_dat = 16'h5A5A;
    lo_from = 5; lo_to = 9;
    push_exp(1'b0, mdl_dat, 12);
    run_txn(1'b0, 1'b1, 16'h0010, 16'h0, 14);
    for (int k = 1; k <= 14; k++) begin
      n_cmp++;
      if ({h_cs0[k], h_rdn[k], h_wrn[k], h_cs1[k], h_mcs[k]} !==
          {!(k >= 1 && k <= 11), !(k >= 2 && k <= 10), 3'b111}) begin
        n_bad++; $display("FAIL io_rd_pins cyc%0d: cs0/rdn/wrn/cs1/mcs=%b%b%b%b%b", k,
                          h_cs0[k], h_rdn[k], h_wrn[k], h_cs1[k], h_mcs[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    MEMDATI = 16'h1111;
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = 1'b0; wb_adr_i = 16'h0042;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    n_cmp++;
    if (RDN !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_pre: RDN=%b want 0", RDN);
    end
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    n_cmp++;
    if ({RDN, WRN, MEMCS_N, IOCS0_N, IOCS1_N, wb_ack_o, wb_err_o} !== 7'b1111100) begin
      n_bad++; $display("FAIL rst_mid_post: got %b want 1111100",
                        {RDN, WRN, MEMCS_N, IOCS0_N, IOCS1_N, wb_ack_o, wb_err_o});
    end
    n_cmp++;
    if (wb_dat_o !== 16'h0) begin
      n_bad++; $display("FAIL rst_mid_dat: got %h want 0", wb_dat_o);
    end
    repeat (4) begin
      @(negedge wb_clk_i);
      n_cmp++;
      if (wb_ack_o !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid_noack: ack=%b want 0", wb_ack_o);
      end
    end
    wb_cyc_i = 1'b0;
    mdl_dat  = 16'h2222;
    MEMDATI  = 16'h2222;
    push_exp(1'b0, mdl_dat, 5);
    run_txn(1'b0, 1'b0, 16'h0044, 16'h0, 7);
  endtask

  task automatic test_cyc_drop();
    int nlow;
    drop_at = 3;
    run_txn(1'b1, 1'b1, 16'h0000, 16'h1357, 12);
    nlow = 0;
    for (int k = 1; k <= 12; k++) if (!h_wrn[k]) nlow++;
    n_cmp++;
    if (nlow !== 4 || h_wrn[2] !== 1'b0 || h_wrn[5] !== 1'b0) begin
      n_bad++; $display("FAIL cyc_drop_wrn: %0d low cycles want 4 in 2..5", nlow);
    end
    n_cmp++;
    if (h_cs0[6] !== 1'b0 || h_cs0[7] !== 1'b1) begin
      n_bad++; $display("FAIL cyc_drop_cs: cs0 c6=%b c7=%b want 0 1", h_cs0[6], h_cs0[7]);
    end
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, mdl_dat, 5);
    run_txn(1'b1, 1'b0, 16'h0002, 16'h0F0F, 6);
    n_cmp++;
    if (DATW !== 16'h0F0F) begin
      n_bad++; $display("FAIL b2b_datw: got %h want 0f0f", DATW);
    end
    MEMDATI = 16'hC3C3;
    mdl_dat = 16'hC3C3;
    push_exp(1'b0, mdl_dat, 5);
    run_txn(1'b0, 1'b0, 16'h0004, 16'h0, 6);
  endtask

  task automatic test_timeout();
`ifdef BUSCTRL_TIMEOUT_EN
    int nerr;
    IODAT1I = 16'h7777;
    lo_from = 1; lo_to = 63;
    mdl_dat = 16'hFFFF;
    push_exp(1'b1, mdl_dat, -1);
    run_txn(1'b0, 1'b1, 16'h0100, 16'h0, 40);
    nerr = 0;
    for (int k = 1; k <= 40; k++) if (h_err[k]) nerr++;
    n_cmp++;
    if (nerr !== 1) begin
      n_bad++; $display("FAIL timeout_err_pulses: got %0d want 1", nerr);
    end
`else
    int nresp;
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = 1'b1; wb_adr_i = 16'h0100;
    IORDY = 1'b0;
    @(posedge wb_clk_i);
    nresp = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge wb_clk_i);
      wb_stb_i = 1'b0;
      if (wb_ack_o || wb_err_o) nresp++;
    end
    n_cmp++;
    if (nresp !== 0) begin
      n_bad++; $display("FAIL stall_resp: got %0d responses want 0", nresp);
    end
    n_cmp++;
    if ({RDN, IOCS1_N} !== 2'b00) begin
      n_bad++; $display("FAIL stall_strobe: RDN/IOCS1_N=%b want 00", {RDN, IOCS1_N});
    end
    wb_cyc_i = 1'b0;
    test_reset();
    IORDY = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_io_read_stretch();
    test_reset_mid();
    test_cyc_drop();
    test_back_to_back();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
